mem_wb_stage_param: RTL

Parametrised memory stage for the 5-stage pipeline: data memory, branch resolution and the MEM/WB pipeline register in one block, placed between EX/MEM and write-back. Over the single-cycle MEM stage it adds:
- byte, half and word loads/stores with sign or zero extension;
- misalignment detection;
- a configurable multi-cycle memory latency with a stall handshake to upstream;
- flush and asynchronous reset of the pipeline register.

---
 rtl/mem_wb_stage_param.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/mem_wb_stage_param.sv
`default_nettype none
// ============================================================================
//  Module      : mem_wb_stage_param
//  Description : Pipeline MEM stage with data memory (byte/half/word access,
//                sign/zero extension, alignment check), branch resolution,
//                configurable access latency with upstream stall, and the
//                MEM/WB pipeline register.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_wb_stage_param #(
  parameter int DEPTH_WORDS = 256,
  parameter int MEM_LATENCY = 0,
  parameter int REG_ADDR_W  = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  MemToReg_in,
  input  logic                  RegWrite_in,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic                  Branch,
  input  logic                  Is_Zero,
  input  logic [1:0]            mem_size,
  input  logic                  mem_unsigned,
  input  logic [31:0]           ALU_Result_in,
  input  logic [31:0]           WriteData,
  input  logic [31:0]           PC_Branch_in,
  input  logic [REG_ADDR_W-1:0] RegisterRd_in,
  output logic                  PCSrc,
  output logic [31:0]           PC_Branch_out,
  output logic                  stall,
  output logic                  misaligned,
  output logic                  MemToReg_out,
  output logic                  RegWrite_out,
  output logic [31:0]           ReadData_out,
  output logic [31:0]           ALU_Result_out,
  output logic [REG_ADDR_W-1:0] RegisterRd_out
);

  localparam int         IDX_W      = $clog2(DEPTH_WORDS);
  localparam logic       HAS_LAT    = (MEM_LATENCY > 0);
  // The entry cycle (in IDLE) is itself the first stall cycle, so the
  // counter only has to cover the remaining MEM_LATENCY-1 stall cycles.
  localparam logic [3:0] LAT_RELOAD = (MEM_LATENCY > 0) ? 4'(MEM_LATENCY - 1) : 4'd0;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    stall_raw;

  logic [31:0]             mem [DEPTH_WORDS];
  logic [IDX_W-1:0]        idx;
  logic [1:0]              lane;
  logic                    access;
  logic                    we;
  logic [31:0]             rd_word;
  logic [7:0]              rd_byte;
  logic [15:0]             rd_half;
  logic [31:0]             load_data;
  logic [31:0]             wr_mask;
  logic [31:0]             wr_rep;
  logic [31:0]             wr_merged;

  logic                    memtoreg_q, memtoreg_d;
  logic                    regwrite_q, regwrite_d;
  logic [31:0]             readdata_q, readdata_d;
  logic [31:0]             alu_result_q, alu_result_d;
  logic [REG_ADDR_W-1:0]   rd_q, rd_d;

  assign idx           = ALU_Result_in[IDX_W+1:2];
  assign lane          = ALU_Result_in[1:0];
  assign PCSrc         = Branch & Is_Zero;
  assign PC_Branch_out = PC_Branch_in;

  // Alignment fault: halves need an even address, words a multiple of four.
  always_comb begin
    misaligned = 1'b0;
    if (MemRead | MemWrite) begin
      if (mem_size == 2'b01)
        misaligned = ALU_Result_in[0];
      else if (mem_size[1])
        misaligned = |ALU_Result_in[1:0];
    end
  end

  assign access = (MemRead | MemWrite) & ~misaligned;

  // Latency FSM: decides stall and counts down the wait cycles.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stall_raw = 1'b0;
    case (state_q)
      IDLE: begin
        if (access && HAS_LAT) begin
          stall_raw = 1'b1;
          state_d   = BUSY;
          cnt_d     = LAT_RELOAD;
        end
      end
      BUSY: begin
        if (cnt_q != 4'd0) begin
          stall_raw = 1'b1;
          cnt_d     = cnt_q - 4'd1;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
    if (flush) begin
      state_d = IDLE;
      cnt_d   = 4'd0;
    end
  end

  // While reset is asserted the stage is idle, so upstream is never held.
  assign stall = stall_raw & ~reset;

  // FSM state and counter registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Load path: pick the lane(s) and extend; non-load accesses yield zero.
  always_comb begin
    rd_word   = mem[idx];
    rd_byte   = rd_word[{lane, 3'b000} +: 8];
    rd_half   = lane[1] ? rd_word[31:16] : rd_word[15:0];
    load_data = 32'd0;
    if (MemRead && !MemWrite && !misaligned) begin
      case (mem_size)
        2'b00:   load_data = {{24{~mem_unsigned & rd_byte[7]}}, rd_byte};
        2'b01:   load_data = {{16{~mem_unsigned & rd_half[15]}}, rd_half};
        default: load_data = rd_word;
      endcase
    end
  end

  // Store path: replicate data across lanes and merge under a lane mask.
  always_comb begin
    case (mem_size)
      2'b00: begin
        wr_mask = 32'h0000_00FF << {lane, 3'b000};
        wr_rep  = {4{WriteData[7:0]}};
      end
      2'b01: begin
        wr_mask = lane[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
        wr_rep  = {2{WriteData[15:0]}};
      end
      default: begin
        wr_mask = 32'hFFFF_FFFF;
        wr_rep  = WriteData;
      end
    endcase
    wr_merged = (rd_word & ~wr_mask) | (wr_rep & wr_mask);
  end

  // A write commits only on the completing edge of an aligned, unflushed access.
  assign we = MemWrite & ~misaligned & ~stall & ~flush & ~reset;

  // Data memory array; contents are deliberately untouched by reset.
  always_ff @(posedge clock) begin
    if (we)
      mem[idx] <= wr_merged;
  end

  // MEM/WB next value: flush zeroes, stall inserts a bubble, otherwise capture.
  always_comb begin
    memtoreg_d   = memtoreg_q;
    regwrite_d   = regwrite_q;
    readdata_d   = readdata_q;
    alu_result_d = alu_result_q;
    rd_d         = rd_q;
    if (flush) begin
      memtoreg_d   = 1'b0;
      regwrite_d   = 1'b0;
      readdata_d   = 32'd0;
      alu_result_d = 32'd0;
      rd_d         = '0;
    end else if (stall) begin
      memtoreg_d   = 1'b0;
      regwrite_d   = 1'b0;
    end else begin
      memtoreg_d   = MemToReg_in;
      regwrite_d   = RegWrite_in & ~misaligned;
      readdata_d   = load_data;
      alu_result_d = ALU_Result_in;
      rd_d         = RegisterRd_in;
    end
  end

  // MEM/WB pipeline register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      memtoreg_q   <= 1'b0;
      regwrite_q   <= 1'b0;
      readdata_q   <= 32'd0;
      alu_result_q <= 32'd0;
      rd_q         <= '0;
    end else begin
      memtoreg_q   <= memtoreg_d;
      regwrite_q   <= regwrite_d;
      readdata_q   <= readdata_d;
      alu_result_q <= alu_result_d;
      rd_q         <= rd_d;
    end
  end

  assign MemToReg_out   = memtoreg_q;
  assign RegWrite_out   = regwrite_q;
  assign ReadData_out   = readdata_q;
  assign ALU_Result_out = alu_result_q;
  assign RegisterRd_out = rd_q;

endmodule
`default_nettype wire
